// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: N-way round-robin arbiter with a registered one-hot grant.
// A grant is held until the owner pulses done, drops its request, or the
// hold counter reaches MAX_HOLD-1. A release caused only by the hold limit
// raises a one-cycle timeout pulse. One idle cycle always separates grants.
module rr_onehot_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 timeout
);

  localparam int             IW        = $clog2(N);
  localparam logic [7:0]     HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0]     HOLD_MAX  = 8'hFF;
  localparam logic [N-1:0]   ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]  LAST_RST  = IW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e          state_q,     state_d;
  logic [N-1:0]    gnt_q,       gnt_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]   gnt_idx_q,   gnt_idx_d;
  logic            timeout_q,   timeout_d;
  logic [7:0]      hold_q,      hold_d;
  logic [IW-1:0]   last_q,      last_d;

  logic [IW:0]     pick_s;
  logic            found_s;
  logic [IW-1:0]   pick_idx_s;
  logic            rel_done_s;
  logic            rel_drop_s;
  logic            rel_hold_s;

  // Circular search starting at l+1: walk offsets from farthest to nearest
  // so the nearest set request is written last and wins. MSB flags a hit.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] r,
                                          input logic [IW-1:0] l);
    logic [IW:0]   res;
    logic [IW-1:0] cand;
    res = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(l) + i) % N);
      if (r[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s     = rr_pick(req, last_q);
  assign found_s    = pick_s[IW];
  assign pick_idx_s = pick_s[IW-1:0];

  // Release causes evaluated against the current owner.
  assign rel_done_s = done;
  assign rel_drop_s = ~req[gnt_idx_q];
  assign rel_hold_s = (hold_q == HOLD_LAST);

  // Next-state and next-output computation for the IDLE/GRANT FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    timeout_d   = 1'b0;
    hold_d      = hold_q;
    last_d      = last_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d     = S_GRANT;
          gnt_d       = ONE_HOT0 << pick_idx_s;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = pick_idx_s;
          last_d      = pick_idx_s;
          hold_d      = 8'd0;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_GRANT: begin
        if (rel_done_s || rel_drop_s || rel_hold_s) begin
          state_d     = S_IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_d      = 8'd0;
          // Only a pure hold-limit release counts as a forced revocation.
          timeout_d   = rel_hold_s & ~rel_done_s & ~rel_drop_s;
        end else begin
          state_d     = S_GRANT;
          hold_d      = (hold_q == HOLD_MAX) ? hold_q : (hold_q + 8'd1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_d      = 8'd0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      timeout_q   <= 1'b0;
      hold_q      <= 8'd0;
      last_q      <= LAST_RST;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      timeout_q   <= timeout_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed testbench for rr_onehot_arbiter (N=4, MAX_HOLD=8).
module tb_rr_onehot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  logic run_inv = 1'b1;

  rr_onehot_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic e_valid,
                         input logic [1:0] e_idx, input logic e_to);
    chk({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
    chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
    chk({tag, ".gnt_idx"},   32'(gnt_idx),   32'(e_idx));
    chk({tag, ".timeout"},   32'(timeout),   32'(e_to));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants sampled on every falling edge.
  always @(negedge clk) begin
    if (run_inv) begin
      chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("inv_valid",   32'(gnt_valid),     32'(|gnt));
    end
  end

  logic [3:0] rot_gnt [5];
  logic [1:0] rot_idx [5];

  initial begin
    rot_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #1;
    chk_out("rst_during", 4'b0000, 1'b0, 2'd0, 1'b0);
    step();
    step();
    chk_out("rst_held", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("rst_after", 4'b0000, 1'b0, 2'd0, 1'b0);

    // done in IDLE with no request has no effect
    done = 1'b1;
    step();
    chk_out("idle_done", 4'b0000, 1'b0, 2'd0, 1'b0);
    done = 1'b0;

    // Full rotation: grant 2 cycles, 1-cycle gap
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("rot_grant", rot_gnt[i], 1'b1, rot_idx[i], 1'b0);
      step();
      chk_out("rot_hold", rot_gnt[i], 1'b1, rot_idx[i], 1'b0);
      done = 1'b1;
      step();
      chk_out("rot_rel", 4'b0000, 1'b0, rot_idx[i], 1'b0);
      done = 1'b0;
    end

    // Skip idle requesters: last=0 -> 0010, then last=1 -> 1000, then 0010
    req = 4'b1010;
    step();
    chk_out("skip_g1", 4'b0010, 1'b1, 2'd1, 1'b0);
    done = 1'b1;
    step();
    chk_out("skip_r1", 4'b0000, 1'b0, 2'd1, 1'b0);
    done = 1'b0;
    step();
    chk_out("skip_g3", 4'b1000, 1'b1, 2'd3, 1'b0);
    done = 1'b1;
    step();
    chk_out("skip_r3", 4'b0000, 1'b0, 2'd3, 1'b0);
    done = 1'b0;
    step();
    chk_out("skip_wrap", 4'b0010, 1'b1, 2'd1, 1'b0);

    // Owner drops its request: release without timeout
    req = 4'b0000;
    step();
    chk_out("drop_rel", 4'b0000, 1'b0, 2'd1, 1'b0);

    // Timeout: 8 cycles of grant, then timeout pulse, then reissue
    req = 4'b0100;
    step();
    chk_out("to_grant", 4'b0100, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk_out("to_hold", 4'b0100, 1'b1, 2'd2, 1'b0);
    end
    step();
    chk_out("to_pulse", 4'b0000, 1'b0, 2'd2, 1'b1);
    step();
    chk_out("to_reissue", 4'b0100, 1'b1, 2'd2, 1'b0);

    // Non-owner activity ignored; done coincides with hold limit
    for (int i = 0; i < 7; i++) begin
      if (i == 2) req = 4'b1101;
      step();
      chk_out("co_hold", 4'b0100, 1'b1, 2'd2, 1'b0);
    end
    done = 1'b1;
    step();
    chk_out("co_rel", 4'b0000, 1'b0, 2'd2, 1'b0);
    done = 1'b0;
    step();
    chk_out("co_next", 4'b1000, 1'b1, 2'd3, 1'b0);

    // Asynchronous reset mid-grant
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst_now", 4'b0000, 1'b0, 2'd0, 1'b0);
    req = 4'b1001;
    step();
    chk_out("arst_held", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("arst_first", 4'b0001, 1'b1, 2'd0, 1'b0);

    run_inv = 1'b0;
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
